psum_accumulator: RTL and testbench

Partial-sum accumulation stage that sits directly downstream of the systolic-array product path. It consumes a stream of products (valid/ready), sums a configured number of terms through an internal `Adder_generic` instance (exact or approximate, selected by parameter), and presents each finished sum on a valid/ready output port with an overflow flag. Drain logic or the next array column connects to this output.

---
 rtl/psum_accumulator.sv | 229 ++++++++++++++++++++++
 tb/tb_psum_accumulator.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_accumulator.sv
// Partial-sum accumulator for the systolic-array product path.
// Sums cfg_len terms through a selectable exact/approximate adder.

module Adder_generic #(
    parameter int WIDTH_A   = 32,
    parameter int WIDTH_B   = 16,
    parameter int WIDTH_OUT = 32,
    parameter int ADD_TYPE  = 0,
    parameter int A_APPROX  = 1,
    parameter int AA_APPROX = 1,
    parameter int B_SIGNED  = 0
) (
    input  logic [WIDTH_A-1:0]   A,
    input  logic [WIDTH_B-1:0]   B,
    input  logic                 Carry,
    output logic [WIDTH_OUT-1:0] OUT
);
    localparam int W  = WIDTH_OUT;
    localparam int K  = (A_APPROX < 0) ? 0 :
                        ((A_APPROX > W) ? W : A_APPROX);
    localparam int KI = (K > 0) ? K - 1 : 0;
    localparam int R  = (A_APPROX < 1) ? 1 : A_APPROX;
    localparam int P  = (AA_APPROX < 0) ? 0 : AA_APPROX;
    localparam logic [W-1:0] LMASK = (W'(1) << K) - W'(1);
    localparam logic [W-1:0] HALF  = (K > 0) ? (W'(1) << KI) : '0;

    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] ideal;
    logic [W-1:0] gear_s;
    logic [W-1:0] gear2_s;
    logic [W-1:0] loa_s;
    logic [W-1:0] trua_s;
    logic [W-1:0] truah_s;
    logic         loa_c;

    assign a = W'(A);

    if (W > WIDTH_B) begin : g_ext
        assign b = {{(W-WIDTH_B){(B_SIGNED != 0) ? B[WIDTH_B-1] : 1'b0}}, B};
    end else begin : g_eq
        assign b = B[W-1:0];
    end

    assign ideal = a + b + W'(Carry);

    // Each GeAr block sees P extra low bits for carry prediction;
    // the 2c variant keeps the top block exact so the sign is right.
    always_comb begin
        int lo;
        int lo2;
        logic [W-1:0] m;
        logic [W-1:0] m2;
        logic [W-1:0] s;
        logic [W-1:0] s2;
        logic [W-1:0] bm;
        lo = 0;
        lo2 = 0;
        m = '0;
        m2 = '0;
        s = '0;
        s2 = '0;
        bm = '0;
        gear_s = '0;
        gear2_s = '0;
        for (int blk = 0; blk < W; blk++) begin
            if (blk * R < W) begin
                lo = blk * R - P;
                if (lo < 0) lo = 0;
                lo2 = ((blk + 1) * R >= W) ? 0 : lo;
                m  = ~((W'(1) << lo) - W'(1));
                m2 = ~((W'(1) << lo2) - W'(1));
                s  = (a & m) + (b & m) + ((lo == 0) ? W'(Carry) : '0);
                s2 = (a & m2) + (b & m2) + ((lo2 == 0) ? W'(Carry) : '0);
                bm = ((W'(1) << R) - W'(1)) << (blk * R);
                gear_s  = gear_s | (s & bm);
                gear2_s = gear2_s | (s2 & bm);
            end
        end
    end

    assign loa_c = (K > 0) ? (a[KI] & b[KI]) : Carry;
    assign loa_s = (((a & ~LMASK) + (b & ~LMASK) + (W'(loa_c) << K)) & ~LMASK)
                 | ((a | b) & LMASK);

    assign trua_s  = (a & ~LMASK) + (b & ~LMASK)
                   + ((K == 0) ? W'(Carry) : '0);
    assign truah_s = trua_s | HALF;

    always_comb begin
        case (ADD_TYPE)
            1:       OUT = gear_s;
            2:       OUT = gear2_s;
            3:       OUT = loa_s;
            4:       OUT = trua_s;
            5:       OUT = truah_s;
            default: OUT = ideal;
        endcase
    end
endmodule

module psum_accumulator #(
    parameter int WIDTH_IN  = 16,
    parameter int WIDTH_ACC = 32,
    parameter int LEN_WIDTH = 8,
    parameter int ADD_TYPE  = 0,
    parameter int A_APPROX  = 1,
    parameter int AA_APPROX = 1,
    parameter int SIGNED    = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [LEN_WIDTH-1:0] cfg_len,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH_IN-1:0]  in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH_ACC-1:0] out_data,
    output logic                 out_ovf,
    output logic                 busy
);
    localparam int W = WIDTH_ACC;

    typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

    state_t               state;
    logic [W-1:0]         acc;
    logic [W-1:0]         res;
    logic [W-1:0]         op_a;
    logic [W-1:0]         b_ext;
    logic [W-1:0]         sum;
    logic [W:0]           exact;
    logic [LEN_WIDTH-1:0] cnt;
    logic [LEN_WIDTH-1:0] len_q;
    logic [LEN_WIDTH-1:0] len_eff;
    logic [LEN_WIDTH-1:0] cur_len;
    logic [LEN_WIDTH-1:0] cur_cnt;
    logic [LEN_WIDTH-1:0] nxt_cnt;
    logic                 acc_ovf;
    logic                 res_ovf;
    logic                 valid_q;
    logic                 first;
    logic                 take;
    logic                 give;
    logic                 last;
    logic                 sovf;
    logic                 uovf;
    logic                 step_ovf;
    logic                 ovf_run;

    assign in_ready = rst_n && ((state != HOLD) || out_ready);
    assign take     = in_valid && in_ready;
    assign give     = valid_q && out_ready;

    // Any accept outside ACC opens a new result (IDLE, or HOLD on deliver).
    assign first   = (state != ACC);
    assign op_a    = first ? '0 : acc;
    assign len_eff = (cfg_len == '0) ? LEN_WIDTH'(1) : cfg_len;
    assign cur_len = first ? len_eff : len_q;
    assign cur_cnt = first ? '0 : cnt;
    assign nxt_cnt = cur_cnt + LEN_WIDTH'(1);
    assign last    = (nxt_cnt == cur_len);

    if (W > WIDTH_IN) begin : g_ext
        assign b_ext = {{(W-WIDTH_IN){(SIGNED != 0) ? in_data[WIDTH_IN-1] : 1'b0}},
                        in_data};
    end else begin : g_eq
        assign b_ext = in_data[W-1:0];
    end

    assign exact    = {1'b0, op_a} + {1'b0, b_ext};
    assign uovf     = exact[W];
    assign sovf     = (op_a[W-1] == b_ext[W-1]) && (exact[W-1] != op_a[W-1]);
    assign step_ovf = (SIGNED != 0) ? sovf : uovf;
    assign ovf_run  = (first ? 1'b0 : acc_ovf) | step_ovf;

    Adder_generic #(
        .WIDTH_A   (W),
        .WIDTH_B   (WIDTH_IN),
        .WIDTH_OUT (W),
        .ADD_TYPE  (ADD_TYPE),
        .A_APPROX  (A_APPROX),
        .AA_APPROX (AA_APPROX),
        .B_SIGNED  (SIGNED)
    ) u_add (
        .A     (op_a),
        .B     (in_data),
        .Carry (1'b0),
        .OUT   (sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            acc     <= '0;
            cnt     <= '0;
            len_q   <= '0;
            acc_ovf <= 1'b0;
            res     <= '0;
            res_ovf <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            if (give) begin
                valid_q <= 1'b0;
                state   <= IDLE;
            end
            if (take) begin
                acc     <= sum;
                cnt     <= nxt_cnt;
                acc_ovf <= ovf_run;
                if (first) len_q <= len_eff;
                if (last) begin
                    state   <= HOLD;
                    valid_q <= 1'b1;
                    res     <= sum;
                    res_ovf <= ovf_run;
                end else begin
                    state <= ACC;
                end
            end
        end
    end

    assign out_valid = valid_q;
    assign out_data  = res;
    assign out_ovf   = res_ovf;
    assign busy      = (state != IDLE);
endmodule

// File: tb/tb_psum_accumulator.sv
// Scoreboard bench: unsigned 32-bit and signed 16-bit accumulators
// share one stimulus stream and are checked against arithmetic models.

module tb_psum_accumulator;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  cfg_len = 8'd0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = 16'd0;
    logic        out_ready = 1'b1;

    logic        u_in_ready, u_out_valid, u_out_ovf, u_busy;
    logic [31:0] u_out_data;
    logic        s_in_ready, s_out_valid, s_out_ovf, s_busy;
    logic [15:0] s_out_data;

    int checks = 0;
    int errors = 0;
    bit rnd_rdy = 1'b0;

    logic [32:0] uq[$];
    logic [16:0] sq[$];

    always #5 clk = ~clk;

    psum_accumulator #(
        .WIDTH_IN(16), .WIDTH_ACC(32), .LEN_WIDTH(8),
        .ADD_TYPE(0), .A_APPROX(1), .AA_APPROX(1), .SIGNED(0)
    ) dut_u (
        .clk(clk), .rst_n(rst_n), .cfg_len(cfg_len),
        .in_valid(in_valid), .in_ready(u_in_ready), .in_data(in_data),
        .out_valid(u_out_valid), .out_ready(out_ready),
        .out_data(u_out_data), .out_ovf(u_out_ovf), .busy(u_busy)
    );

    psum_accumulator #(
        .WIDTH_IN(16), .WIDTH_ACC(16), .LEN_WIDTH(8),
        .ADD_TYPE(0), .A_APPROX(1), .AA_APPROX(1), .SIGNED(1)
    ) dut_s (
        .clk(clk), .rst_n(rst_n), .cfg_len(cfg_len),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .out_data(s_out_data), .out_ovf(s_out_ovf), .busy(s_busy)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: results defined by term lists and plain arithmetic.
    initial begin : model
        int n, len, sa, t;
        bit uo, so, hold, er;
        longint unsigned ua, ut;
        logic [31:0] tv;
        n = 0; len = 1; sa = 0; t = 0;
        uo = 0; so = 0; hold = 0; er = 0;
        ua = 0; ut = 0; tv = 0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                n = 0;
                hold = 0;
                uq.delete();
                sq.delete();
                chk("rst_in_ready_u", u_in_ready, 0);
                chk("rst_in_ready_s", s_in_ready, 0);
            end else begin
                er = !hold || out_ready;
                chk("in_ready_u", u_in_ready, er);
                chk("in_ready_s", s_in_ready, er);
                if (hold && out_ready) hold = 0;
                if (in_valid && er) begin
                    if (n == 0) begin
                        len = (cfg_len == 0) ? 1 : int'(cfg_len);
                        ua = 0; uo = 0; sa = 0; so = 0;
                    end
                    ut = ua + 64'(in_data);
                    if (ut > 64'hFFFF_FFFF) uo = 1;
                    ua = ut & 64'hFFFF_FFFF;
                    t = sa + int'($signed(in_data));
                    if (t > 32767 || t < -32768) so = 1;
                    tv = t;
                    sa = int'($signed(tv[15:0]));
                    n++;
                    if (n == len) begin
                        uq.push_back({uo, ua[31:0]});
                        sq.push_back({so, tv[15:0]});
                        n = 0;
                        hold = 1;
                    end
                end
            end
        end
    end

    initial begin : monitor
        logic pv, pr;
        logic [31:0] pud;
        logic [15:0] psd;
        logic [32:0] e;
        logic [16:0] es;
        pv = 0; pr = 0; pud = 0; psd = 0; e = 0; es = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_out_valid_u", u_out_valid, 0);
                chk("rst_out_data_u", u_out_data, 0);
                chk("rst_out_ovf_u", u_out_ovf, 0);
                chk("rst_busy_u", u_busy, 0);
                chk("rst_out_valid_s", s_out_valid, 0);
                chk("rst_out_data_s", s_out_data, 0);
                chk("rst_out_ovf_s", s_out_ovf, 0);
                chk("rst_busy_s", s_busy, 0);
                pv = 0;
            end else begin
                chk("valid_vs_pending_u", u_out_valid, uq.size() != 0);
                chk("valid_vs_pending_s", s_out_valid, sq.size() != 0);
                if (pv && !pr) begin
                    chk("hold_valid_u", u_out_valid, 1);
                    chk("hold_data_u", u_out_data, pud);
                    chk("hold_data_s", s_out_data, psd);
                end
                if (u_out_valid && out_ready) begin
                    if (uq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_result_u actual=%0h required=none", u_out_data);
                    end else begin
                        e = uq.pop_front();
                        chk("data_u", u_out_data, e[31:0]);
                        chk("ovf_u", u_out_ovf, e[32]);
                    end
                end
                if (s_out_valid && out_ready) begin
                    if (sq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_result_s actual=%0h required=none", s_out_data);
                    end else begin
                        es = sq.pop_front();
                        chk("data_s", s_out_data, es[15:0]);
                        chk("ovf_s", s_out_ovf, es[16]);
                    end
                end
                pv = u_out_valid;
                pr = out_ready;
                pud = u_out_data;
                psd = s_out_data;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send(input logic [15:0] d);
        int k;
        k = 0;
        in_valid = 1'b1;
        in_data = d;
        forever begin
            @(negedge clk);
            if (u_in_ready) break;
            k++;
            if (k > 200) begin
                checks++; errors++;
                $display("FAIL send_timeout actual=stalled required=accept");
                break;
            end
            tick();
        end
        tick();
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin : driver
        rst_n = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        cfg_len = 8'd4;
        send(16'd1); send(16'd2); send(16'd3); send(16'd4);
        idle(3);

        cfg_len = 8'd2;
        send(16'h7FFF); send(16'h0001);
        send(16'd5); send(16'hFFFD);
        idle(3);

        out_ready = 1'b0;
        cfg_len = 8'd3;
        fork
            begin
                send(16'd1); send(16'd2); send(16'd3);
                send(16'd100); send(16'd200); send(16'd300);
                in_valid = 1'b0;
            end
            begin
                int k;
                k = 0;
                while (!u_out_valid && k < 100) begin
                    @(negedge clk);
                    k++;
                end
                if (!u_out_valid) begin
                    checks++; errors++;
                    $display("FAIL stall_result actual=no_valid required=valid");
                end
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        idle(3);

        cfg_len = 8'd0;
        send(16'd7);
        cfg_len = 8'd1;
        send(16'd8); send(16'd9);
        idle(3);

        cfg_len = 8'd4;
        send(16'd5); send(16'd6);
        in_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(16'd1); send(16'd1); send(16'd1); send(16'd1);
        idle(3);

        cfg_len = 8'd4;
        send(16'd10);
        cfg_len = 8'd2;
        idle(1); send(16'd20);
        idle(1); send(16'd30);
        idle(1); send(16'd40);
        idle(3);

        rnd_rdy = 1'b1;
        repeat (500) begin
            cfg_len = 8'($urandom_range(0, 5));
            if ($urandom_range(0, 3) == 0) idle(1);
            send(16'($urandom));
        end
        in_valid = 1'b0;
        rnd_rdy = 1'b0;
        out_ready = 1'b1;
        idle(10);
        chk("drained_u", uq.size(), 0);
        chk("drained_s", sq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
